// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared definitions for the UART host controller.
//   - I/O register map addresses
//   - RX drain and TX sequencing FSM state encodings
//   - bit positions inside the status byte
package uart_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_ACK    = 2'd1,
        RX_SETTLE = 2'd2
    } rx_state_e;

    typedef enum logic {
        TX_EMPTY = 1'b0,
        TX_HOLD  = 1'b1
    } tx_state_e;

    localparam int unsigned ST_RX_AVAIL  = 0;
    localparam int unsigned ST_FIFO_FULL = 1;
    localparam int unsigned ST_TX_READY  = 2;
    localparam int unsigned ST_OVR       = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO holding received UART data.
// Ports:
//   clk, rst    clock, synchronous active-high reset (flushes pointers)
//   push, din   write a byte (ignored when full)
//   pop         discard head entry (ignored when empty)
//   dout        head entry, combinational
//   full, empty occupancy flags
// Pointers carry one extra wrap bit so full/empty are distinguishable.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: bus-side UART controller. Drains receiver bytes into an RX
// FIFO, sequences transmitter loads and holds the baud divisor.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   iocs/iorw/ioaddr/wdata   one-cycle bus access (iorw 1=read)
//   rdata                    registered read data, held until next read
//   rx_avail, tx_ready       FIFO non-empty / TX holding register empty
//   rx_data/rx_rda/rec_enable receiver handshake
//   tx_data/tx_load/tx_tbr   transmitter handshake
//   div_value/div_load       baud divisor and its load strobe
// Register map: 00 R pop / W TX byte; 01 R status; 10 divisor low; 11 divisor high.
// Build option: define UART_CTRL_OVERRUN_EN for a sticky overrun status bit.
module uart_host_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned RX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd325
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iocs,
    input  logic        iorw,
    input  logic [1:0]  ioaddr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rx_avail,
    output logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_rda,
    output logic        rec_enable,
    output logic [7:0]  tx_data,
    output logic        tx_load,
    input  logic        tx_tbr,
    output logic [15:0] div_value,
    output logic        div_load
);

    rx_state_e   rx_state_q, rx_state_d;
    tx_state_e   tx_state_q, tx_state_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_load_q, tx_load_d;
    logic [15:0] div_value_q, div_value_d;
    logic [7:0]  div_lo_q, div_lo_d;
    logic        div_load_q, div_load_d;
    logic        start_q;

    logic        rd_acc, wr_acc;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [7:0]  status;
    logic        ovr;

    assign rd_acc = iocs & iorw;
    assign wr_acc = iocs & ~iorw;

    // A byte is only taken from IDLE and only when there is room, so the
    // FIFO never sees a push while full.
    assign fifo_push = (rx_state_q == RX_IDLE) & rx_rda & ~fifo_full;
    assign fifo_pop  = rd_acc & (ioaddr == ADDR_DATA);

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef UART_CTRL_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (rd_acc && (ioaddr == ADDR_STATUS)) ovr_d = 1'b0;
        if (rx_rda && fifo_full)               ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ovr_q <= 1'b0;
        else     ovr_q <= ovr_d;
    end

    assign ovr = ovr_q;
`else
    assign ovr = 1'b0;
`endif

    always_comb begin
        status               = '0;
        status[ST_RX_AVAIL]  = ~fifo_empty;
        status[ST_FIFO_FULL] = fifo_full;
        status[ST_TX_READY]  = (tx_state_q == TX_EMPTY);
        status[ST_OVR]       = ovr;
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        tx_state_d  = tx_state_q;
        rdata_d     = rdata_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        div_value_d = div_value_q;
        div_lo_d    = div_lo_q;
        // The post-reset divisor strobe rides the same flop as write strobes.
        div_load_d  = start_q;

        case (rx_state_q)
            RX_IDLE:   if (fifo_push) rx_state_d = RX_ACK;
            RX_ACK:    rx_state_d = RX_SETTLE;
            RX_SETTLE: rx_state_d = RX_IDLE;
            default:   rx_state_d = RX_IDLE;
        endcase

        case (tx_state_q)
            TX_EMPTY: begin
                if (wr_acc && (ioaddr == ADDR_DATA)) begin
                    tx_data_d  = wdata;
                    tx_state_d = TX_HOLD;
                end
            end
            TX_HOLD: begin
                if (tx_tbr) begin
                    tx_load_d  = 1'b1;
                    tx_state_d = TX_EMPTY;
                end
            end
            default: tx_state_d = TX_EMPTY;
        endcase

        if (wr_acc && (ioaddr == ADDR_DIV_LO)) div_lo_d = wdata;
        if (wr_acc && (ioaddr == ADDR_DIV_HI)) begin
            div_value_d = {wdata, div_lo_q};
            div_load_d  = 1'b1;
        end

        if (rd_acc) begin
            case (ioaddr)
                ADDR_DATA:   rdata_d = fifo_empty ? 8'h00 : fifo_dout;
                ADDR_STATUS: rdata_d = status;
                ADDR_DIV_LO: rdata_d = div_value_q[7:0];
                default:     rdata_d = div_value_q[15:8];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            tx_state_q  <= TX_EMPTY;
            rdata_q     <= '0;
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
            div_value_q <= DIV_RESET;
            div_lo_q    <= '0;
            div_load_q  <= 1'b0;
            start_q     <= 1'b1;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            rdata_q     <= rdata_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            div_value_q <= div_value_d;
            div_lo_q    <= div_lo_d;
            div_load_q  <= div_load_d;
            start_q     <= 1'b0;
        end
    end

    assign rdata      = rdata_q;
    assign rx_avail   = ~fifo_empty;
    assign tx_ready   = (tx_state_q == TX_EMPTY);
    assign rec_enable = (rx_state_q == RX_ACK);
    assign tx_data    = tx_data_q;
    assign tx_load    = tx_load_q;
    assign div_value  = div_value_q;
    assign div_load   = div_load_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: self-checking bench for uart_host_ctrl. A behavioural
// model (byte queue for the RX FIFO, plain variables for divisor state)
// supplies every expected value. Honours UART_CTRL_OVERRUN_EN for status.
module tb_uart_host_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iocs = 1'b0;
    logic        iorw = 1'b0;
    logic [1:0]  ioaddr = 2'b00;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        rx_avail, tx_ready;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rda = 1'b0;
    logic        rec_enable;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tx_tbr = 1'b0;
    logic [15:0] div_value;
    logic        div_load;

    int checks = 0;
    int failures = 0;

    logic [7:0]  model_q[$];
    logic [15:0] exp_div;
    logic [7:0]  exp_lo;

`ifdef UART_CTRL_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_host_ctrl #(
        .RX_DEPTH  (4),
        .DIV_RESET (16'd325)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rx_avail   (rx_avail),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_rda     (rx_rda),
        .rec_enable (rec_enable),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_tbr     (tx_tbr),
        .div_value  (div_value),
        .div_load   (div_load)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; wdata = d;
        tick();
        iocs = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        tick();
        iocs = 1'b0; iorw = 1'b0;
        d = rdata;
    endtask

    // Receiver model: present a byte until acknowledged, then drop rda.
    task automatic rx_send(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        rx_data = b; rx_rda = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rec_enable) begin
                rx_rda = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        rx_rda = 1'b0;
    endtask

    function automatic logic [7:0] exp_status(input bit ovr, input bit txr, input int n);
        return {4'b0, ovr, txr, (n == 4), (n != 0)};
    endfunction

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        checks++; if (rec_enable !== 1'b0 || tx_load !== 1'b0 || div_load !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b%b exp=000", rec_enable, tx_load, div_load); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (div_value !== 16'd325) begin failures++; $display("FAIL reset_div got=%0d exp=325", div_value); end
        checks++; if (rx_avail !== 1'b0 || tx_ready !== 1'b1) begin failures++; $display("FAIL reset_flags got avail=%b ready=%b exp 0/1", rx_avail, tx_ready); end
        rst = 1'b0;
        cnt = (div_load === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (div_load === 1'b1) cnt++;
        end
        checks++; if (cnt != 1) begin failures++; $display("FAIL reset_div_load_pulse got=%0d cycles exp=1", cnt); end
        exp_div = 16'd325; exp_lo = 8'h00;
        begin
            logic [7:0] s;
            bus_read(2'b01, s);
            checks++; if (s !== 8'h04) begin failures++; $display("FAIL reset_status got=%h exp=04", s); end
        end
    endtask

    task automatic test_rx_single();
        bit ok;
        logic [7:0] d;
        rx_send(8'hA5, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rx_single_ack got=none exp=rec_enable"); end
        tick();
        checks++; if (rec_enable !== 1'b0) begin failures++; $display("FAIL rx_single_ack_width got=%b exp=0", rec_enable); end
        checks++; if (rx_avail !== 1'b1) begin failures++; $display("FAIL rx_single_avail got=%b exp=1", rx_avail); end
        bus_read(2'b00, d);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL rx_single_data got=%h exp=a5", d); end
        checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL rx_single_drained got=%b exp=0", rx_avail); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int acks;
        logic [7:0] d;
        for (int i = 1; i <= 4; i++) begin
            rx_send(8'(i), ok);
            checks++; if (!ok) begin failures++; $display("FAIL full_push%0d got=no_ack exp=ack", i); end
        end
        rx_data = 8'h05; rx_rda = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rec_enable) acks++;
        end
        checks++; if (acks != 0) begin failures++; $display("FAIL full_no_ack got=%0d acks exp=0", acks); end
        bus_read(2'b01, d);
        checks++; if (d !== exp_status(OVR_EN, 1'b1, 4)) begin failures++; $display("FAIL full_status got=%h exp=%h", d, exp_status(OVR_EN, 1'b1, 4)); end
        bus_read(2'b00, d);
        checks++; if (d !== 8'h01) begin failures++; $display("FAIL full_pop1 got=%h exp=01", d); end
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rec_enable) begin ok = 1'b1; break; end
            tick();
        end
        rx_rda = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL full_late_accept got=no_ack exp=ack"); end
        for (int i = 2; i <= 5; i++) begin
            bus_read(2'b00, d);
            checks++; if (d !== 8'(i)) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", i, d, 8'(i)); end
        end
        bus_read(2'b01, d);
        checks++; if (d !== exp_status(OVR_EN, 1'b1, 0)) begin failures++; $display("FAIL ovr_sticky got=%h exp=%h", d, exp_status(OVR_EN, 1'b1, 0)); end
        bus_read(2'b01, d);
        checks++; if (d !== 8'h04) begin failures++; $display("FAIL ovr_cleared got=%h exp=04", d); end
    endtask

    task automatic test_empty_pop();
        logic [7:0] d;
        bus_read(2'b00, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL empty_pop got=%h exp=00", d); end
        checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL empty_pop_avail got=%b exp=0", rx_avail); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] d;
        rx_send(8'h11, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_first got=no_ack exp=ack"); end
        repeat (3) tick();
        rx_data = 8'h22; rx_rda = 1'b1;
        bus_read(2'b00, d);
        checks++; if (d !== 8'h11) begin failures++; $display("FAIL b2b_pop got=%h exp=11", d); end
        checks++; if (rec_enable !== 1'b1) begin failures++; $display("FAIL b2b_push got=%b exp=1", rec_enable); end
        rx_rda = 1'b0;
        checks++; if (rx_avail !== 1'b1) begin failures++; $display("FAIL b2b_count got=%b exp=1", rx_avail); end
        bus_read(2'b00, d);
        checks++; if (d !== 8'h22) begin failures++; $display("FAIL b2b_second got=%h exp=22", d); end
        checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", rx_avail); end
    endtask

    task automatic test_tx();
        int cnt;
        tx_tbr = 1'b0;
        bus_write(2'b00, 8'h3C);
        checks++; if (tx_ready !== 1'b0 || tx_data !== 8'h3C) begin failures++; $display("FAIL tx_latch got ready=%b data=%h exp 0/3c", tx_ready, tx_data); end
        bus_write(2'b00, 8'h55);
        checks++; if (tx_data !== 8'h3C) begin failures++; $display("FAIL tx_drop got=%h exp=3c", tx_data); end
        cnt = (tx_load === 1'b1) ? 1 : 0;
        tx_tbr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tx_load === 1'b1) cnt++;
        end
        tx_tbr = 1'b0;
        checks++; if (cnt != 1) begin failures++; $display("FAIL tx_load_pulse got=%0d exp=1", cnt); end
        checks++; if (tx_ready !== 1'b1 || tx_data !== 8'h3C) begin failures++; $display("FAIL tx_done got ready=%b data=%h exp 1/3c", tx_ready, tx_data); end
    endtask

    task automatic test_div();
        logic [7:0] d;
        bus_write(2'b10, 8'h1B);
        checks++; if (div_value !== 16'd325 || div_load !== 1'b0) begin failures++; $display("FAIL div_lo_only got=%h/%b exp=0145/0", div_value, div_load); end
        bus_write(2'b11, 8'h00);
        checks++; if (div_value !== 16'h001B || div_load !== 1'b1) begin failures++; $display("FAIL div_hi got=%h/%b exp=001b/1", div_value, div_load); end
        tick();
        checks++; if (div_load !== 1'b0) begin failures++; $display("FAIL div_load_width got=%b exp=0", div_load); end
        exp_div = 16'h001B; exp_lo = 8'h1B;
        bus_read(2'b11, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL div_read_hi got=%h exp=00", d); end
        bus_read(2'b10, d);
        checks++; if (d !== 8'h1B) begin failures++; $display("FAIL div_read_lo got=%h exp=1b", d); end
        bus_write(2'b01, 8'hAA);
        checks++; if (rdata !== 8'h1B) begin failures++; $display("FAIL rdata_hold got=%h exp=1b", rdata); end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] d, b, e;
        int op;
        model_q.delete();
        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 5));
            b  = 8'($urandom);
            if (op == 0 && model_q.size() == 4) op = 1;
            case (op)
                0: begin
                    rx_send(b, ok);
                    checks++; if (!ok) begin failures++; $display("FAIL rand_push n=%0d got=no_ack exp=ack", n); end
                    model_q.push_back(b);
                end
                1: begin
                    e = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
                    bus_read(2'b00, d);
                    checks++; if (d !== e) begin failures++; $display("FAIL rand_pop n=%0d got=%h exp=%h", n, d, e); end
                end
                2: begin
                    e = exp_status(1'b0, 1'b1, model_q.size());
                    bus_read(2'b01, d);
                    checks++; if (d !== e) begin failures++; $display("FAIL rand_status n=%0d got=%h exp=%h", n, d, e); end
                end
                3: begin
                    bus_write(2'b10, b);
                    exp_lo = b;
                end
                4: begin
                    bus_write(2'b11, b);
                    exp_div = {b, exp_lo};
                    checks++; if (div_value !== exp_div || div_load !== 1'b1) begin failures++; $display("FAIL rand_div n=%0d got=%h/%b exp=%h/1", n, div_value, div_load, exp_div); end
                end
                default: begin
                    bus_read(2'b10, d);
                    checks++; if (d !== exp_div[7:0]) begin failures++; $display("FAIL rand_div_lo n=%0d got=%h exp=%h", n, d, exp_div[7:0]); end
                    bus_read(2'b11, d);
                    checks++; if (d !== exp_div[15:8]) begin failures++; $display("FAIL rand_div_hi n=%0d got=%h exp=%h", n, d, exp_div[15:8]); end
                end
            endcase
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        logic [7:0] d;
        tx_tbr = 1'b0;
        bus_write(2'b00, 8'h99);
        rx_send(8'h77, ok);
        checks++; if (!ok || rx_avail !== 1'b1) begin failures++; $display("FAIL rst_mid_setup got ack=%b avail=%b exp 1/1", ok, rx_avail); end
        rst = 1'b1;
        tick();
        checks++; if (rec_enable !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got=%b exp=0", rec_enable); end
        checks++; if (rx_avail !== 1'b0 || tx_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_flush got avail=%b ready=%b exp 0/1", rx_avail, tx_ready); end
        checks++; if (div_value !== 16'd325 || tx_data !== 8'h00 || rdata !== 8'h00) begin failures++; $display("FAIL rst_mid_regs got div=%h tx=%h rd=%h exp 0145/00/00", div_value, tx_data, rdata); end
        rst = 1'b0;
        repeat (3) tick();
        bus_read(2'b00, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_mid_pop got=%h exp=00", d); end
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_fifo_full();
        test_empty_pop();
        test_back_to_back();
        test_tx();
        test_div();
        test_random();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
